sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter SRAM_WAIT_CYCLES, default 3, idle-bus wait cycles after the two half-word transfers.
REQ-002 Parameter DATA_BASE_ADDR, default 32'd1024, byte address of SRAM word 0.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rd_en  in  1  read request from memory stage.
REQ-006 wr_en  in  1  write request from memory stage.
REQ-007 address  in  32  byte address (ALU result).
REQ-008 write_data  in  32  store value (Rm value).
REQ-009 read_data  out  32  load result, valid when ready=1 in DONE after a read.
REQ-010 ready  out  1  0 = access in progress, pipeline shall freeze.
REQ-011 sram_addr  out  18  half-word address to SRAM.
REQ-012 sram_dq_out / sram_dq_in / sram_dq_oe  out 16 / in 16 / out 1  split tri-state data bus.
REQ-013 sram_we_n  out  1  active-low SRAM write strobe.

Function
REQ-014 FSM states IDLE, LO, HI, WAIT, DONE; IDLE->LO when rd_en|wr_en sampled high, LO->HI, HI->WAIT, WAIT->DONE when wait counter reaches SRAM_WAIT_CYCLES-1, DONE->IDLE unconditionally.
REQ-015 Access latency 5+SRAM_WAIT_CYCLES cycles from request edge to DONE-exit edge (default 8 cycles, ready=1 in the last one).
REQ-016 ready = 1 in DONE, or in IDLE with rd_en=wr_en=0; ready = 0 otherwise (combinational, same cycle as request).
REQ-017 address, write_data and op type latched on IDLE->LO; input changes during LO..DONE ignored.
REQ-018 wr_en and rd_en both high: write performed, read ignored, read_data unchanged.
REQ-019 Word index = (address - DATA_BASE_ADDR) >> 2, truncated to 17 bits (wraps modulo 2^17); address[1:0] ignored.
REQ-020 sram_addr = {word_index, 1'b0} in LO, {word_index, 1'b1} in HI, held at last value elsewhere.
REQ-021 Write: sram_we_n=0 and sram_dq_oe=1 in LO and HI only; sram_dq_out = write_data[15:0] in LO, [31:16] in HI.
REQ-022 Read: sram_dq_in captured into read_data[15:0] at LO exit edge and [31:16] at HI exit edge; read_data holds until next read.
REQ-023 Outside write LO/HI: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-024 A request still asserted in IDLE after DONE is a new access.

Reset
REQ-025 rst high on any edge, including mid-access: state IDLE, wait counter 0, read_data 0, sram_addr 0, sram_we_n 1, sram_dq_oe 0, any pending write discarded.

Configuration
REQ-026 Macro SRAM_POSTED_WRITE_EN compiles in a one-entry write buffer.
REQ-027 With it: wr_en in IDLE with buffer empty latches address/data, ready stays 1 that cycle, write proceeds LO..DONE in background with ready=1 unless a new request arrives.
REQ-028 With it: any request arriving while the buffered write drains sees ready=0 until that write finishes and its own access reaches DONE.
REQ-029 Without it: writes behave exactly as reads per REQ-014..REQ-016.

Structure
REQ-030 Shared package holds FSM state enum, DATA_BASE_ADDR default, SRAM address/data width constants.
REQ-031 One sub-module sram_wait_counter (load, enable, terminal-count output) is natural; FSM stays in top.

Verification
REQ-032 Write address 1024 data 32'hDEADBEEF -> sram_addr 0 then 1, dq_out 16'hBEEF then 16'hDEAD, we_n low exactly 2 cycles, ready low 7 cycles.
REQ-033 Read address 1024 after REQ-032 with SRAM model -> read_data 32'hDEADBEEF on the 8th cycle, ready=1 that cycle only.
REQ-034 rd_en and wr_en both high, address 1028, data 32'h12345678 -> write to sram_addr 2/3, read_data unchanged.
REQ-035 rst asserted in HI of a write -> next cycle IDLE, we_n=1, oe=0, ready=1 with no request.
REQ-036 SRAM_POSTED_WRITE_EN: write then read issued next cycle -> write ready=1 immediately, read ready=0 until write drains plus 8 read cycles.
REQ-037 Address 1024+4*2^17 -> sram_addr 0 (wrap).

Source files
------------

// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller_pkg
//  Description : Shared definitions for the SRAM controller. Holds the access
//                FSM state encoding, the default SRAM base byte address, the
//                SRAM bus widths and the word-index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_controller_pkg;

    localparam int          c_sram_addr_w    = 18;   // half-word address width
    localparam int          c_sram_data_w    = 16;   // SRAM data bus width
    localparam int          c_word_idx_w     = 17;   // 32-bit word index width
    localparam logic [31:0] c_data_base_addr = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } sram_state_e;

    // Byte address -> 32-bit word index. The subtraction wraps in 32 bits
    // and the result is truncated, so the index wraps modulo 2^17 and the
    // two byte-offset bits never reach the SRAM.
    function automatic logic [c_word_idx_w-1:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return c_word_idx_w'((addr - base) >> 2);
    endfunction

endpackage : sram_controller_pkg
`default_nettype wire

// File: rtl/sram_controller_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wait_counter
//  Description : Idle-bus wait counter for the SRAM controller. Cleared by
//                load, advances while enable is high, and raises a registered
//                terminal count one cycle after the count reaches
//                WAIT_CYCLES-1, so the owner spends WAIT_CYCLES+1 cycles in
//                its wait state.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load            - clear count and terminal flag
//                enable          - advance the count
//                tc              - terminal count reached (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int                 c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;
    logic               r_tc;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (enable) begin
            // Saturate at the last value; the flag stays up until reloaded.
            r_tc <= (r_count == c_last);
            if (r_count != c_last) begin
                r_count <= r_count + c_one;
            end
        end
    end

    assign tc = r_tc;

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : Memory-stage SRAM controller. Splits each 32-bit load/store
//                into two 16-bit SRAM transfers (low half then high half),
//                followed by idle-bus wait cycles, and freezes the pipeline
//                through ready while an access is in flight.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                rd_en, wr_en                  - access requests
//                address, write_data           - byte address, store value
//                read_data, ready              - load result, pipeline go
//                sram_addr                     - SRAM half-word address
//                sram_dq_out/_in/_oe           - split tri-state data bus
//                sram_we_n                     - active-low write strobe
//  Config      : SRAM_POSTED_WRITE_EN - one-entry posted write buffer; a
//                write is accepted with ready=1 and drains in background.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          SRAM_WAIT_CYCLES = 3,
    parameter logic [31:0] DATA_BASE_ADDR   = c_data_base_addr
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic [c_sram_addr_w-1:0] sram_addr,
    output logic [c_sram_data_w-1:0] sram_dq_out,
    input  logic [c_sram_data_w-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n
);

    sram_state_e             r_state;
    logic                    r_is_write;
    logic [c_word_idx_w-1:0] r_word_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_read_data;
    logic [c_sram_addr_w-1:0] r_sram_addr;
    logic [c_sram_data_w-1:0] r_dq_out;
    logic                    r_dq_oe;
    logic                    r_we_n;
`ifdef SRAM_POSTED_WRITE_EN
    logic                    r_posted;   // current access is a buffered write
`endif

    logic                    w_req;
    logic                    w_wait_done;
    logic                    w_ready;
    logic [c_word_idx_w-1:0] w_word_idx;

    assign w_req      = rd_en | wr_en;
    assign w_word_idx = word_index(address, DATA_BASE_ADDR);

    sram_wait_counter #(
        .WAIT_CYCLES (SRAM_WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (r_state == ST_IDLE),
        .enable (r_state == ST_WAIT),
        .tc     (w_wait_done)
    );

    // Access FSM. All SRAM-side outputs are registered so they change on the
    // edge that enters LO/HI and stay stable for the whole transfer cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_is_write  <= 1'b0;
            r_word_idx  <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
`ifdef SRAM_POSTED_WRITE_EN
            r_posted    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state     <= ST_LO;
                        // A simultaneous read is dropped: write wins.
                        r_is_write  <= wr_en;
                        r_word_idx  <= w_word_idx;
                        r_wdata     <= write_data;
                        r_sram_addr <= {w_word_idx, 1'b0};
                        if (wr_en) begin
                            r_we_n   <= 1'b0;
                            r_dq_oe  <= 1'b1;
                            r_dq_out <= write_data[15:0];
                        end
`ifdef SRAM_POSTED_WRITE_EN
                        r_posted    <= wr_en;
`endif
                    end
                end
                ST_LO: begin
                    r_state     <= ST_HI;
                    r_sram_addr <= {r_word_idx, 1'b1};
                    if (r_is_write) begin
                        r_dq_out <= r_wdata[31:16];
                    end else begin
                        r_read_data[15:0] <= sram_dq_in;
                    end
                end
                ST_HI: begin
                    r_state  <= ST_WAIT;
                    r_we_n   <= 1'b1;
                    r_dq_oe  <= 1'b0;
                    r_dq_out <= '0;
                    if (!r_is_write) begin
                        r_read_data[31:16] <= sram_dq_in;
                    end
                end
                ST_WAIT: begin
                    if (w_wait_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
`ifdef SRAM_POSTED_WRITE_EN
                    r_posted <= 1'b0;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline handshake. Combinational so a new request drops ready in the
    // same cycle it is presented.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
`ifdef SRAM_POSTED_WRITE_EN
            // A write is absorbed by the empty buffer without stalling.
            ST_IDLE: w_ready = !rd_en || wr_en;
            // A buffered write's completion belongs to nobody in the pipe;
            // any newly arriving request waits for its own access.
            ST_DONE: w_ready = r_posted ? !w_req : 1'b1;
            default: w_ready = r_posted && !w_req;
`else
            ST_IDLE: w_ready = !w_req;
            ST_DONE: w_ready = 1'b1;
            default: w_ready = 1'b0;
`endif
        endcase
    end

    assign ready       = w_ready;
    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_controller
//  Description : Self-checking bench for sram_controller with a 16-bit SRAM
//                model. Expected SRAM write transfers and load results are
//                queued when stimulus is driven and compared when the DUT
//                produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_ent_t;

    wr_ent_t     wr_q[$];
    logic [31:0] rd_q[$];
    wr_ent_t     mon_e;
    logic [31:0] exp_rd;

    logic [15:0] mem [0:1023];

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM model (aliased to 1K half-words).
    assign sram_dq_in = mem[sram_addr[9:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_out;
    end

    // SRAM bus monitor: every strobed cycle must match the next queued
    // half-word transfer; every other cycle must leave the bus released.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!sram_we_n) begin
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_write unexpected strobe: addr=%h dq=%h", sram_addr, sram_dq_out);
                end else begin
                    mon_e = wr_q.pop_front();
                    if (sram_addr !== mon_e.a || sram_dq_out !== mon_e.d || sram_dq_oe !== 1'b1) begin
                        errors++;
                        $display("FAIL sram_write: got addr=%h dq=%h oe=%b, want addr=%h dq=%h oe=1",
                                 sram_addr, sram_dq_out, sram_dq_oe, mon_e.a, mon_e.d);
                    end
                end
            end else if (sram_dq_oe !== 1'b0 || sram_dq_out !== 16'h0) begin
                errors++;
                $display("FAIL idle_bus: got oe=%b dq=%h, want oe=0 dq=0000", sram_dq_oe, sram_dq_out);
            end
        end
    end

    function automatic void push_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic [16:0] idx;
        off = a - 32'd1024;
        idx = off[18:2];
        wr_q.push_back({idx, 1'b0, d[15:0]});
        wr_q.push_back({idx, 1'b1, d[31:16]});
    endfunction

    // Drives one request (entered at posedge+1) and holds it until ready.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, output int low, output int wlow,
                              output logic [31:0] rdv);
        low  = 0;
        wlow = 0;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sram_we_n) wlow++;
            if (ready) break;
            low++;
        end
        rdv = read_data;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b1)   begin errors++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe: got %b want 0", sram_dq_oe); end
        checks++; if (sram_addr !== 18'h0)  begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
        checks++; if (read_data !== 32'h0)  begin errors++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq_out: got %h want 0", sram_dq_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        exp_rd = 32'h0;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_write;
        int low, wlow;
        logic [31:0] rdv;
        push_write(32'd1024, 32'hDEADBEEF);
        run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, low, wlow, rdv);
        checks++; if (low !== 7)  begin errors++; $display("FAIL write_ready_low: got %0d cycles want 7", low); end
        checks++; if (wlow !== 2) begin errors++; $display("FAIL write_we_low: got %0d cycles want 2", wlow); end
        checks++; if (rdv !== exp_rd) begin errors++; $display("FAIL write_read_data_kept: got %h want %h", rdv, exp_rd); end
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] d, input string nm);
        int low, wlow;
        logic [31:0] rdv, e;
        rd_q.push_back(d);
        run_access(1'b1, 1'b0, a, 32'h0, low, wlow, rdv);
        e = rd_q.pop_front();
        exp_rd = e;
        checks++; if (low !== 7)  begin errors++; $display("FAIL %s_ready_low: got %0d cycles want 7", nm, low); end
        checks++; if (rdv !== e)  begin errors++; $display("FAIL %s_data: got %h want %h", nm, rdv, e); end
        checks++; if (wlow !== 0) begin errors++; $display("FAIL %s_we_low: got %0d want 0", nm, wlow); end
    endtask

    task automatic test_both_high;
        int low, wlow;
        logic [31:0] rdv;
        push_write(32'd1028, 32'h12345678);
        run_access(1'b1, 1'b1, 32'd1028, 32'h12345678, low, wlow, rdv);
        checks++; if (low !== 7)  begin errors++; $display("FAIL both_ready_low: got %0d want 7", low); end
        checks++; if (wlow !== 2) begin errors++; $display("FAIL both_we_low: got %0d want 2", wlow); end
        checks++; if (rdv !== exp_rd) begin errors++; $display("FAIL both_read_data_kept: got %h want %h", rdv, exp_rd); end
    endtask

    task automatic test_wrap;
        int low, wlow;
        logic [31:0] rdv;
        push_write(32'd1024 + 32'd524288, 32'hA5A55A5A);
        run_access(1'b0, 1'b1, 32'd1024 + 32'd524288, 32'hA5A55A5A, low, wlow, rdv);
        checks++; if (low !== 7) begin errors++; $display("FAIL wrap_ready_low: got %0d want 7", low); end
        // Byte-offset bits must be ignored: 1027 is word 0.
        test_read(32'd1027, 32'hA5A55A5A, "wrap_read");
    endtask

    task automatic test_back_to_back;
        int seg_low[2];
        int n;
        logic [31:0] e;
        seg_low[0] = 0; seg_low[1] = 0; n = 0;
        rd_q.push_back(32'hA5A55A5A);
        rd_q.push_back(32'h12345678);
        rd_en = 1'b1; address = 32'd1024;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                e = rd_q.pop_front();
                checks++;
                if (read_data !== e) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", n, read_data, e); end
                exp_rd = e;
                n++;
                if (n == 2) break;
            end else begin
                seg_low[n]++;
            end
            // Address change mid-access must not affect the first access.
            if (i == 0) begin @(posedge clk); #1; address = 32'd1028; end
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        checks++; if (n !== 2)          begin errors++; $display("FAIL b2b_count: got %0d accesses want 2", n); end
        checks++; if (seg_low[0] !== 7) begin errors++; $display("FAIL b2b_low0: got %0d want 7", seg_low[0]); end
        checks++; if (seg_low[1] !== 7) begin errors++; $display("FAIL b2b_low1: got %0d want 7", seg_low[1]); end
    endtask

    task automatic test_below_base;
        int low, wlow;
        logic [31:0] rdv;
        push_write(32'd1020, 32'h0BADC0DE);
        run_access(1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, low, wlow, rdv);
        checks++; if (wlow !== 2) begin errors++; $display("FAIL below_we_low: got %0d want 2", wlow); end
    endtask

    task automatic test_reset_mid_write;
        push_write(32'd1032, 32'h55AA33CC);
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1032; write_data = 32'h55AA33CC;
        @(negedge clk);                 // IDLE with request
        @(posedge clk); #1;
        @(negedge clk);                 // LO
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);                 // HI, reset pending
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL midrst_ready: got %b want 1", ready); end
        checks++; if (sram_we_n !== 1'b1)  begin errors++; $display("FAIL midrst_we_n: got %b want 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe: got %b want 0", sram_dq_oe); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", sram_addr); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL midrst_read_data: got %h want 0", read_data); end
        @(posedge clk); #1;
        test_read(32'd1024, 32'hA5A55A5A, "post_reset_read");
    endtask

`ifdef SRAM_POSTED_WRITE_EN
    task automatic test_posted_write;
        int low;
        logic [31:0] e;
        low = 0;
        push_write(32'd1024, 32'hCAFEF00D);
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL posted_write_ready: got %b want 1", ready); end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b1;
        rd_q.push_back(32'hCAFEF00D);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
        end
        e = rd_q.pop_front();
        checks++; if (low !== 14)     begin errors++; $display("FAIL posted_read_low: got %0d want 14", low); end
        checks++; if (read_data !== e) begin errors++; $display("FAIL posted_read_data: got %h want %h", read_data, e); end
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        test_reset;
`ifdef SRAM_POSTED_WRITE_EN
        test_posted_write;
`else
        test_write;
        test_read(32'd1024, 32'hDEADBEEF, "read");
        test_both_high;
        test_wrap;
        test_back_to_back;
        test_below_base;
        test_reset_mid_write;
`endif
        repeat (2) @(negedge clk);
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL wr_queue_drain: got %0d left want 0", wr_q.size()); end
        checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL rd_queue_drain: got %0d left want 0", rd_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_sram_controller
`default_nettype wire
